nibble_serial_alu_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_alu_ctrl
// PURPOSE
//  Sequencer that runs WIDTH-bit add/subtract/compare through one shared 4-bit add/sub slice, one nibble per clock.
//  Stores the inter-nibble carry, assembles the result and produces 8085-style flags (CY, Z, S, V).
//  Sits between the register file/decoder (operand source) and the accumulator/flag register (result sink).
//  Valid/ready on both sides.
// PARAMETERS
//  NIBBLES   4   operand width in nibbles; WIDTH = 4*NIBBLES (legal 1..8)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operation request
//  in_ready   out  1        controller can accept (IDLE only)
//  op         in   2        00 ADD, 01 SUB, 10 CMP, 11 ADC
//  cy_in      in   1        carry-in, used by ADC only
//  a          in   WIDTH    operand A (minuend)
//  b          in   WIDTH    operand B (subtrahend)
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        sink accepts result
//  result     out  WIDTH    ADD/SUB/ADC: sum/difference; CMP: a unchanged
//  flag_cy    out  1        carry (ADD/ADC) or borrow = ~carry_out (SUB/CMP)
//  flag_z     out  1        arithmetic result == 0 (CMP uses the difference)
//  flag_s     out  1        MSB of arithmetic result
//  flag_v     out  1        signed overflow = c_out ^ c_into_MSB of last nibble
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1 after release, out_valid=0, result=0, all flags 0, nibble index=0, carry reg=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, op, and the initial carry, then go to RUN with idx=0.
//    Initial carry: SUB/CMP=1, ADC=cy_in, ADD=0.
//  - RUN: in_ready=0. Each cycle the slice computes a[idx]+b'[idx]+carry, where b'=~b for SUB/CMP.
//    The 4-bit sum is written to result nibble idx; carry reg <= slice c_out; idx++.
//    On idx==NIBBLES-1: compute flags from final slice outputs plus the zero accumulator, then go to DONE.
//  - Latency: accept edge at cycle 0 gives out_valid=1 after exactly NIBBLES further edges (4 for default).
//  - DONE: out_valid=1. result/flags are held stable until out_valid&&out_ready; that edge returns to IDLE with out_valid=0.
//    A new request is not accepted in that same cycle (in_ready=0 in DONE), so throughput is 1 op per NIBBLES+2 cycles.
//  - Zero detect: running OR of nibble sums, cleared on accept. No wide compare at the end.
//  - CMP: the difference is computed for flags only. The result register is loaded with latched a and never overwritten.
//  - in_valid while busy: ignored, no queueing. Upstream must hold the request until in_ready.
//  - out_ready asserted outside DONE: no effect.
//  - Operands are latched on accept. Later changes to a/b/op/cy_in during RUN have no effect.
//  - Reset mid-RUN or mid-DONE: immediate abort to the reset values above. The partial result is discarded and no out_valid pulse occurs.
//  - Wrap-around: all arithmetic is modulo 2^WIDTH. Carry/borrow out of the MSB appears only in flag_cy.
//  - idx counter width = clog2(NIBBLES) (min 1). NIBBLES=1 degenerates to a single RUN cycle.
// STRUCTURE
//  - Shared package (alu_pkg): op encoding localparams OP_ADD/OP_SUB/OP_CMP/OP_ADC.
//    Also state encoding localparams S_IDLE/S_RUN/S_DONE.
//  - One sub-module: nibble_addsub_slice (4-bit ripple of full adders with explicit cin).
//    Outputs sum[3:0], c_out, and c3 (carry into bit 3) for V.
//    The B inversion (XOR with sub) is done inside the slice.
//  - Controller holds FSM, idx counter, operand/result shift registers, carry reg and flag logic.
// TESTING (NIBBLES=4)
//  1. ADD a=0x1234 b=0x0FCD -> result 0x2201, CY=0 Z=0 S=0 V=0; out_valid exactly 4 clocks after accept.
//  2. SUB a=0x0001 b=0x0002 -> result 0xFFFF, CY(borrow)=1 Z=0 S=1 V=0.
//  3. ADD a=0x7FFF b=0x0001 -> result 0x8000, CY=0 S=1 V=1; ADC a=0xFFFF b=0x0000 cy_in=1 -> 0x0000, CY=1 Z=1.
//  4. CMP a=0x5A5A b=0x5A5A -> result 0x5A5A, Z=1 CY=0; CMP a=0x0010 b=0x0020 -> result 0x0010, CY=1 Z=0.
//  5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/flags/out_valid stable.
//     in_valid pulses during RUN/DONE are ignored. Release -> IDLE next edge.
//  6. Assert rst_n=0 during RUN idx=2 -> out_valid=0, result=0, flags=0 immediately.
//     After release in_ready=1, and the next ADD 0x0003+0x0004 returns 0x0007.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and controller state encodings shared by the nibble-serial ALU
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ADC = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/nibble_addsub_slice.sv
// nibble_addsub_slice: 4-bit ripple add/sub (b inverted when sub); ports a,b,sub,cin -> sum,c_out,c3 (carry into bit 3)
module nibble_addsub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       c3
);
  logic [3:0] bx;
  logic [4:0] c;
  assign bx = b ^ {4{sub}};
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i] = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  assign c_out = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: nibble-serial ADD/SUB/CMP/ADC sequencer; in: clk,rst_n,in_valid,op,cy_in,a,b,out_ready; out: in_ready,out_valid,result,flag_cy/z/s/v
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic                 cy_in,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 flag_cy,
  output logic                 flag_z,
  output logic                 flag_s,
  output logic                 flag_v
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  logic [1:0] state, state_nx, op_r;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, zacc, sub, last, accept, c_out, c3;
  logic [3:0] sum;
  assign sub = op_r == OP_SUB || op_r == OP_CMP;
  assign last = idx == IW'(NIBBLES - 1);
  assign accept = in_valid && in_ready;
  nibble_addsub_slice u_slice (
    .a    (a_r[4*idx +: 4]),
    .b    (b_r[4*idx +: 4]),
    .sub  (sub),
    .cin  (carry),
    .sum  (sum),
    .c_out(c_out),
    .c3   (c3)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (in_valid ? S_RUN : S_IDLE) :
               state == S_RUN  ? (last ? S_DONE : S_RUN) :
               state == S_DONE ? (out_ready ? S_IDLE : S_DONE) : S_IDLE;
  always_comb begin
    in_ready = state == S_IDLE;
    out_valid = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      op_r <= OP_ADD;
      carry <= 1'b0;
      zacc <= 1'b0;
      idx <= '0;
      result <= '0;
      flag_cy <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      op_r <= op;
      carry <= op == OP_ADC ? cy_in : (op == OP_SUB || op == OP_CMP);
      zacc <= 1'b0;
      idx <= '0;
      result <= op == OP_CMP ? a : '0;
    end else if (state == S_RUN) begin
      if (op_r != OP_CMP) result[4*idx +: 4] <= sum;
      carry <= c_out;
      zacc <= zacc | (|sum);
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        flag_cy <= c_out ^ sub;
        flag_z <= ~(zacc | (|sum));
        flag_s <= sum[3];
        flag_v <= c_out ^ c3;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb_nibble_serial_alu_ctrl: directed self-checking bench for the nibble-serial ALU controller
module tb_nibble_serial_alu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] op = 2'b00;
  logic cy_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] result;
  logic flag_cy, flag_z, flag_s, flag_v;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cy_in(cy_in), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_cy(flag_cy),
    .flag_z(flag_z), .flag_s(flag_s), .flag_v(flag_v)
  );
  task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; cy_in = c; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic c, output int lat);
    start_op(o, x, y, c);
    wait_done(lat);
  endtask
  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic test_reset;
    #12;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (result !== 16'h0) begin errors++; $display("FAIL rst_result: got %h want 0000", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {flag_cy, flag_z, flag_s, flag_v}); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid2: got %b want 0", out_valid); end
  endtask
  task automatic test_add;
    int lat;
    run_op(2'b00, 16'h1234, 16'h0FCD, 1'b0, lat);
    checks += 3;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    if (result !== 16'h2201) begin errors++; $display("FAIL add_result: got %h want 2201", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b want 0000", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
  endtask
  task automatic test_sub;
    int lat;
    run_op(2'b01, 16'h0001, 16'h0002, 1'b0, lat);
    checks += 2;
    if (result !== 16'hFFFF) begin errors++; $display("FAIL sub_result: got %h want ffff", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b1010) begin errors++; $display("FAIL sub_flags: got %b want 1010", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
  endtask
  task automatic test_overflow;
    int lat;
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, lat);
    checks += 2;
    if (result !== 16'h8000) begin errors++; $display("FAIL ovf_result: got %h want 8000", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0011) begin errors++; $display("FAIL ovf_flags: got %b want 0011", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
    run_op(2'b11, 16'hFFFF, 16'h0000, 1'b1, lat);
    checks += 2;
    if (result !== 16'h0000) begin errors++; $display("FAIL adc_result: got %h want 0000", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b1100) begin errors++; $display("FAIL adc_flags: got %b want 1100", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
    run_op(2'b11, 16'h0100, 16'h0200, 1'b0, lat);
    checks += 2;
    if (result !== 16'h0300) begin errors++; $display("FAIL adc0_result: got %h want 0300", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0000) begin errors++; $display("FAIL adc0_flags: got %b want 0000", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
  endtask
  task automatic test_cmp;
    int lat;
    run_op(2'b10, 16'h5A5A, 16'h5A5A, 1'b0, lat);
    checks += 2;
    if (result !== 16'h5A5A) begin errors++; $display("FAIL cmp_eq_result: got %h want 5a5a", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0100) begin errors++; $display("FAIL cmp_eq_flags: got %b want 0100", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
    run_op(2'b10, 16'h0010, 16'h0020, 1'b0, lat);
    checks += 2;
    if (result !== 16'h0010) begin errors++; $display("FAIL cmp_lt_result: got %h want 0010", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b1010) begin errors++; $display("FAIL cmp_lt_flags: got %b want 1010", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
  endtask
  task automatic test_backpressure;
    int lat;
    start_op(2'b00, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    op = 2'b01; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
      if (result !== 16'h3333) begin errors++; $display("FAIL bp_hold_result%0d: got %h want 3333", i, result); end
      if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0000) begin errors++; $display("FAIL bp_hold_flags%0d: got %b want 0000", i, {flag_cy, flag_z, flag_s, flag_v}); end
    end
    in_valid = 1'b0;
    drain();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got %b want 1", in_ready); end
  endtask
  task automatic test_reset_mid_run;
    int lat;
    run_op(2'b01, 16'h0001, 16'h0002, 1'b0, lat);
    drain();
    start_op(2'b00, 16'h1111, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    if (result !== 16'h0) begin errors++; $display("FAIL midrst_result: got %h want 0000", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b want 0000", {flag_cy, flag_z, flag_s, flag_v}); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    run_op(2'b00, 16'h0003, 16'h0004, 1'b0, lat);
    checks += 3;
    if (lat !== 4) begin errors++; $display("FAIL post_latency: got %0d want 4", lat); end
    if (result !== 16'h0007) begin errors++; $display("FAIL post_result: got %h want 0007", result); end
    if ({flag_cy, flag_z, flag_s, flag_v} !== 4'b0000) begin errors++; $display("FAIL post_flags: got %b want 0000", {flag_cy, flag_z, flag_s, flag_v}); end
    drain();
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_cmp();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
